regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Producer side of the register file write port: merges two writeback sources onto the single write port.
- The in-order pipeline writeback path has strict priority.
- Results from long-latency units (divider, non-blocking loads) are buffered in a small FIFO and drained into idle write-port cycles.
- Exposes per-address pending flags and a stall request so the hazard unit can resolve RAW/WAW against queued writes.

Parameters:
- ADDRESS_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width
- FIFO_DEPTH, 4, auxiliary queue entries; power of two, >= 2

Ports:
- iClk  input  1  clock, rising edge
- iRst  input  1  asynchronous reset, active-high
- iPipeWriteEn  input  1  pipeline writeback valid; always accepted
- iPipeWriteAddress  input  ADDRESS_WIDTH  pipeline destination register
- iPipeData  input  DATA_WIDTH  pipeline result
- iAuxValid  input  1  long-latency result valid
- iAuxWriteAddress  input  ADDRESS_WIDTH  long-latency destination register
- iAuxData  input  DATA_WIDTH  long-latency result
- oAuxReady  output  1  queue can accept; transfer occurs when iAuxValid && oAuxReady at a rising edge
- oWriteEn  output  1  to register file write enable (registered)
- oWriteAddress  output  ADDRESS_WIDTH  to register file write address (registered)
- oDataOut  output  DATA_WIDTH  to register file data in (registered)
- iLookupAddress1  input  ADDRESS_WIDTH  decode-stage source register 1
- iLookupAddress2  input  ADDRESS_WIDTH  decode-stage source register 2
- oPending1  output  1  a queued aux write targets iLookupAddress1
- oPending2  output  1  a queued aux write targets iLookupAddress2
- oStallRequest  output  1  queue full; hazard unit must hold long-latency issue
- oFifoCount  output  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (async, active-high): oWriteEn=0, oWriteAddress=0, oDataOut=0, FIFO empty, oFifoCount=0, oAuxReady=0 while iRst is high. All registered state clears immediately on iRst rise.
- oAuxReady = !full (combinational from count), forced 0 during reset. No push when full, even if a pop occurs in the same cycle.
- Issue selection, evaluated each cycle, registered on the next edge (1-cycle latency):
  - Pipe valid with iPipeWriteAddress != 0: issue pipe write.
  - Otherwise, FIFO non-empty: pop head and issue it.
  - Otherwise: oWriteEn=0; address/data hold their previous values.
- Writes to x0:
  - Pipe write to address 0 counts as idle, so the FIFO may drain that cycle.
  - Aux transfer to address 0 is handshaken (consumed) but not enqueued.
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits. Pointers wrap modulo FIFO_DEPTH. Count is updated as +push -pop; simultaneous push and pop leaves the count unchanged.
- oPending1/2: combinational OR over valid entries of (entry address == lookup address). Forced 0 when the lookup address is 0. The entry being popped in the current cycle still counts as pending this cycle.
- oStallRequest = (count == FIFO_DEPTH).
- Ordering: the block never reorders within a source. Cross-source WAW ordering is the hazard unit's responsibility, using oPending.
- Reset mid-operation: queued entries are discarded with no write issued.

Optional Feature:
- Macro: REGFILE_AUX_BYPASS_EN.
- Defined: if FIFO empty, no valid non-x0 pipe write, and an aux transfer occurs, the aux write is issued directly on the next edge (1-cycle latency) and not enqueued. count stays 0 and pending flags are not raised.
- Undefined: every non-x0 aux write is enqueued first. Minimum latency is 2 cycles (enqueue edge, then issue edge).

Test Plan:
- Reset release, then pipe write x5=0x0000_00AA -> next cycle oWriteEn=1, oWriteAddress=5, oDataOut=0xAA; following cycle oWriteEn=0.
- Pipe idle, aux x7=0x1234 (bypass off) -> oFifoCount=1, oPending1=1 when iLookupAddress1=7; next edge oWriteEn=1 to x7=0x1234, count 0. With REGFILE_AUX_BYPASS_EN: written one cycle earlier, count stays 0.
- Pipe writes every cycle x1..x6 while aux pushes x10..x13 -> oFifoCount reaches 4, oAuxReady=0, oStallRequest=1, no aux write issued. Pipe idle for 4 cycles -> x10,x11,x12,x13 written in order, count returns to 0.
- Aux transfer to x0, and pipe write to x0 with FIFO holding x9=0x55 -> aux x0 not enqueued (count unchanged); x9=0x55 issued in the pipe-x0 cycle.
- Fill FIFO to 3 entries, push and pop in the same cycle across pointer wrap -> count stays 3, FIFO order preserved over 2*FIFO_DEPTH operations.
- Assert iRst with 3 entries queued -> outputs/count clear asynchronously; after release no stale writes appear, oAuxReady=1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Merges the in-order pipeline writeback and long-latency (divider / non-blocking
// load) results onto the single register file write port. The pipeline has strict
// priority. Long-latency results wait in a small circular FIFO and drain into idle
// write-port cycles. Per-address pending flags and a stall request let the hazard
// unit resolve RAW/WAW hazards against queued writes.
//
// Optional feature macro: REGFILE_AUX_BYPASS_EN
//   When it is defined, an aux result that arrives while the FIFO is empty and the
//   port is otherwise idle is written directly on the next edge and not enqueued.
//
// Ports:
//   iClk, iRst                  clock (rising edge), asynchronous active-high reset
//   iPipeWriteEn/Address/Data   pipeline writeback; always accepted
//   iAuxValid/WriteAddress/Data long-latency result; handshaked with oAuxReady
//   oAuxReady                   queue can accept (not full, low during reset)
//   oWriteEn/Address/oDataOut   registered register-file write port
//   iLookupAddress1/2           decode-stage source registers
//   oPending1/2                 a queued aux write targets the lookup address
//   oStallRequest               queue full
//   oFifoCount                  occupied entries
module regfile_write_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          iClk,
   input  logic                          iRst,
   input  logic                          iPipeWriteEn,
   input  logic [ADDRESS_WIDTH-1:0]      iPipeWriteAddress,
   input  logic [DATA_WIDTH-1:0]         iPipeData,
   input  logic                          iAuxValid,
   input  logic [ADDRESS_WIDTH-1:0]      iAuxWriteAddress,
   input  logic [DATA_WIDTH-1:0]         iAuxData,
   output logic                          oAuxReady,
   output logic                          oWriteEn,
   output logic [ADDRESS_WIDTH-1:0]      oWriteAddress,
   output logic [DATA_WIDTH-1:0]         oDataOut,
   input  logic [ADDRESS_WIDTH-1:0]      iLookupAddress1,
   input  logic [ADDRESS_WIDTH-1:0]      iLookupAddress2,
   output logic                          oPending1,
   output logic                          oPending2,
   output logic                          oStallRequest,
   output logic [$clog2(FIFO_DEPTH):0]   oFifoCount
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]         FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0]         PTR_ONE    = PTR_W'(1);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_X0    = {ADDRESS_WIDTH{1'b0}};

   // FIFO storage and bookkeeping
   logic [ADDRESS_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]         r_rd_ptr;
   logic [PTR_W-1:0]         r_wr_ptr;
   logic [CNT_W-1:0]         r_count;

   logic w_full;
   logic w_empty;
   logic w_pipe_issue;
   logic w_aux_xfer;
   logic w_aux_nonzero;
   logic w_bypass;
   logic w_push;
   logic w_pop;
   logic w_hit1;
   logic w_hit2;

   assign w_full        = (r_count == FULL_COUNT);
   assign w_empty       = (r_count == {CNT_W{1'b0}});
   assign oAuxReady     = ~w_full & ~iRst;
   assign oStallRequest = w_full;
   assign oFifoCount    = r_count;

   // A pipeline write to x0 does not occupy the port, so the FIFO may drain then.
   assign w_pipe_issue  = iPipeWriteEn & (iPipeWriteAddress != ADDR_X0);
   assign w_aux_xfer    = iAuxValid & oAuxReady;
   assign w_aux_nonzero = (iAuxWriteAddress != ADDR_X0);
   assign w_pop         = ~w_pipe_issue & ~w_empty;

`ifdef REGFILE_AUX_BYPASS_EN
   // Direct issue only when nothing older is queued, so ordering is preserved.
   assign w_bypass = w_aux_xfer & w_aux_nonzero & w_empty & ~w_pipe_issue;
`else
   assign w_bypass = 1'b0;
`endif

   // Aux writes to x0 are consumed by the handshake but never stored.
   assign w_push = w_aux_xfer & w_aux_nonzero & ~w_bypass;

   // FIFO pointers and occupancy count
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_rd_ptr <= {PTR_W{1'b0}};
         r_wr_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO entry storage; stale entries are never read because validity comes from r_count
   always_ff @(posedge iClk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= iAuxWriteAddress;
         r_fifo_data[r_wr_ptr] <= iAuxData;
      end
   end

   // Registered write port: pipeline first, then FIFO head, then optional bypass
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oWriteEn      <= 1'b0;
         oWriteAddress <= ADDR_X0;
         oDataOut      <= {DATA_WIDTH{1'b0}};
      end else if (w_pipe_issue) begin
         oWriteEn      <= 1'b1;
         oWriteAddress <= iPipeWriteAddress;
         oDataOut      <= iPipeData;
      end else if (w_pop) begin
         oWriteEn      <= 1'b1;
         oWriteAddress <= r_fifo_addr[r_rd_ptr];
         oDataOut      <= r_fifo_data[r_rd_ptr];
      end else if (w_bypass) begin
         oWriteEn      <= 1'b1;
         oWriteAddress <= iAuxWriteAddress;
         oDataOut      <= iAuxData;
      end else begin
         oWriteEn      <= 1'b0;
         oWriteAddress <= oWriteAddress;
         oDataOut      <= oDataOut;
      end
   end

   // Address match over the occupied slots, walking from the head; the head being
   // popped this cycle is still occupied and therefore still reported.
   always_comb begin
      logic [PTR_W-1:0] v_idx;
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      v_idx  = {PTR_W{1'b0}};
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         v_idx = r_rd_ptr + PTR_W'(k);
         if (CNT_W'(k) < r_count) begin
            if (r_fifo_addr[v_idx] == iLookupAddress1) begin
               w_hit1 = 1'b1;
            end else begin
               w_hit1 = w_hit1;
            end
            if (r_fifo_addr[v_idx] == iLookupAddress2) begin
               w_hit2 = 1'b1;
            end else begin
               w_hit2 = w_hit2;
            end
         end else begin
            w_hit1 = w_hit1;
            w_hit2 = w_hit2;
         end
      end
   end

   // x0 is hardwired zero, so it never carries a hazard
   assign oPending1 = w_hit1 & (iLookupAddress1 != ADDR_X0);
   assign oPending2 = w_hit2 & (iLookupAddress2 != ADDR_X0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   localparam int DEPTH = 4;

   logic        iClk, iRst;
   logic        iPipeWriteEn;
   logic [4:0]  iPipeWriteAddress;
   logic [31:0] iPipeData;
   logic        iAuxValid;
   logic [4:0]  iAuxWriteAddress;
   logic [31:0] iAuxData;
   logic        oAuxReady;
   logic        oWriteEn;
   logic [4:0]  oWriteAddress;
   logic [31:0] oDataOut;
   logic [4:0]  iLookupAddress1, iLookupAddress2;
   logic        oPending1, oPending2, oStallRequest;
   logic [2:0]  oFifoCount;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
   ent_t        m_q[$];
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   regfile_write_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
      .iClk(iClk), .iRst(iRst),
      .iPipeWriteEn(iPipeWriteEn), .iPipeWriteAddress(iPipeWriteAddress), .iPipeData(iPipeData),
      .iAuxValid(iAuxValid), .iAuxWriteAddress(iAuxWriteAddress), .iAuxData(iAuxData),
      .oAuxReady(oAuxReady), .oWriteEn(oWriteEn), .oWriteAddress(oWriteAddress), .oDataOut(oDataOut),
      .iLookupAddress1(iLookupAddress1), .iLookupAddress2(iLookupAddress2),
      .oPending1(oPending1), .oPending2(oPending2), .oStallRequest(oStallRequest),
      .oFifoCount(oFifoCount));

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   // Reference model: a queue of waiting aux writes plus the expected write port.
   function automatic logic model_pending(logic [4:0] la);
      if (la == 5'd0) return 1'b0;
      foreach (m_q[i]) if (m_q[i].a == la) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
   endtask

   // Advance one clock edge and update the model with the inputs seen at that edge.
   task automatic tick();
      bit ready, pipe_issue, xfer, byp;
      @(posedge iClk);
      ready      = (m_q.size() < DEPTH);
      pipe_issue = iPipeWriteEn && (iPipeWriteAddress != 5'd0);
      xfer       = iAuxValid && ready;
      byp        = 1'b0;
      if (pipe_issue) begin
         m_we = 1'b1; m_wa = iPipeWriteAddress; m_wd = iPipeData;
      end else if (m_q.size() > 0) begin
         m_we = 1'b1; m_wa = m_q[0].a; m_wd = m_q[0].d;
         void'(m_q.pop_front());
      end
`ifdef REGFILE_AUX_BYPASS_EN
      else if (xfer && iAuxWriteAddress != 5'd0) begin
         m_we = 1'b1; m_wa = iAuxWriteAddress; m_wd = iAuxData; byp = 1'b1;
      end
`endif
      else begin
         m_we = 1'b0;
      end
      if (xfer && iAuxWriteAddress != 5'd0 && !byp) m_q.push_back({iAuxWriteAddress, iAuxData});
      #1;
   endtask

   task automatic idle_inputs();
      iPipeWriteEn = 1'b0; iPipeWriteAddress = 5'd0; iPipeData = 32'd0;
      iAuxValid = 1'b0; iAuxWriteAddress = 5'd0; iAuxData = 32'd0;
   endtask

   task automatic test_reset();
      iRst = 1'b1; idle_inputs();
      iLookupAddress1 = 5'd0; iLookupAddress2 = 5'd0;
      model_reset();
      #12;
      n_checks++; if (oWriteEn !== 1'b0) $display("FAIL rst_we got=%0h exp=0", oWriteEn); else n_pass++;
      n_checks++; if (oWriteAddress !== 5'd0) $display("FAIL rst_wa got=%0h exp=0", oWriteAddress); else n_pass++;
      n_checks++; if (oDataOut !== 32'd0) $display("FAIL rst_data got=%0h exp=0", oDataOut); else n_pass++;
      n_checks++; if (oFifoCount !== 3'd0) $display("FAIL rst_count got=%0h exp=0", oFifoCount); else n_pass++;
      n_checks++; if (oAuxReady !== 1'b0) $display("FAIL rst_ready got=%0h exp=0", oAuxReady); else n_pass++;
      @(negedge iClk); iRst = 1'b0; #1;
      n_checks++; if (oAuxReady !== 1'b1) $display("FAIL rel_ready got=%0h exp=1", oAuxReady); else n_pass++;
      tick();
   endtask

   task automatic test_pipe_write();
      iPipeWriteEn = 1'b1; iPipeWriteAddress = 5'd5; iPipeData = 32'h0000_00AA;
      tick();
      n_checks++; if (oWriteEn !== 1'b1) $display("FAIL pipe_we got=%0h exp=1", oWriteEn); else n_pass++;
      n_checks++; if (oWriteAddress !== 5'd5) $display("FAIL pipe_wa got=%0h exp=5", oWriteAddress); else n_pass++;
      n_checks++; if (oDataOut !== 32'hAA) $display("FAIL pipe_data got=%0h exp=aa", oDataOut); else n_pass++;
      idle_inputs();
      tick();
      n_checks++; if (oWriteEn !== 1'b0) $display("FAIL pipe_we_off got=%0h exp=0", oWriteEn); else n_pass++;
      n_checks++; if (oWriteAddress !== 5'd5) $display("FAIL pipe_wa_hold got=%0h exp=5", oWriteAddress); else n_pass++;
   endtask

   task automatic test_aux_single();
      iAuxValid = 1'b1; iAuxWriteAddress = 5'd7; iAuxData = 32'h1234;
      iLookupAddress1 = 5'd7;
      tick();
      idle_inputs(); #1;
`ifdef REGFILE_AUX_BYPASS_EN
      n_checks++; if (oWriteEn !== 1'b1) $display("FAIL byp_we got=%0h exp=1", oWriteEn); else n_pass++;
      n_checks++; if (oWriteAddress !== 5'd7) $display("FAIL byp_wa got=%0h exp=7", oWriteAddress); else n_pass++;
      n_checks++; if (oDataOut !== 32'h1234) $display("FAIL byp_data got=%0h exp=1234", oDataOut); else n_pass++;
      n_checks++; if (oFifoCount !== 3'd0) $display("FAIL byp_count got=%0h exp=0", oFifoCount); else n_pass++;
      n_checks++; if (oPending1 !== 1'b0) $display("FAIL byp_pend got=%0h exp=0", oPending1); else n_pass++;
      tick();
`else
      n_checks++; if (oFifoCount !== 3'd1) $display("FAIL aux_count got=%0h exp=1", oFifoCount); else n_pass++;
      n_checks++; if (oPending1 !== 1'b1) $display("FAIL aux_pend got=%0h exp=1", oPending1); else n_pass++;
      n_checks++; if (oWriteEn !== 1'b0) $display("FAIL aux_we_early got=%0h exp=0", oWriteEn); else n_pass++;
      tick();
      n_checks++; if (oWriteEn !== 1'b1) $display("FAIL aux_we got=%0h exp=1", oWriteEn); else n_pass++;
      n_checks++; if (oWriteAddress !== 5'd7) $display("FAIL aux_wa got=%0h exp=7", oWriteAddress); else n_pass++;
      n_checks++; if (oDataOut !== 32'h1234) $display("FAIL aux_data got=%0h exp=1234", oDataOut); else n_pass++;
      n_checks++; if (oFifoCount !== 3'd0) $display("FAIL aux_count0 got=%0h exp=0", oFifoCount); else n_pass++;
`endif
      iLookupAddress1 = 5'd0;
   endtask

   task automatic test_fill_stall();
      for (int k = 0; k < 6; k++) begin
         iPipeWriteEn = 1'b1; iPipeWriteAddress = 5'(k + 1); iPipeData = 32'h100 + 32'(k);
         iAuxValid = (k < 4); iAuxWriteAddress = 5'(10 + k); iAuxData = 32'h200 + 32'(k);
         #1;
         n_checks++; if (oAuxReady !== (k < 4)) $display("FAIL fill_ready k=%0d got=%0h exp=%0h", k, oAuxReady, (k < 4)); else n_pass++;
         tick();
         n_checks++; if (oWriteAddress !== 5'(k + 1) || oWriteEn !== 1'b1) $display("FAIL fill_pipe k=%0d got=%0h exp=%0h", k, oWriteAddress, k + 1); else n_pass++;
      end
      idle_inputs(); #1;
      n_checks++; if (oFifoCount !== 3'd4) $display("FAIL full_count got=%0h exp=4", oFifoCount); else n_pass++;
      n_checks++; if (oStallRequest !== 1'b1) $display("FAIL full_stall got=%0h exp=1", oStallRequest); else n_pass++;
      n_checks++; if (oAuxReady !== 1'b0) $display("FAIL full_ready got=%0h exp=0", oAuxReady); else n_pass++;
      for (int j = 0; j < 4; j++) begin
         tick();
         n_checks++; if (oWriteEn !== 1'b1 || oWriteAddress !== 5'(10 + j) || oDataOut !== 32'h200 + 32'(j))
            $display("FAIL drain j=%0d got=%0h:%0h exp=%0h:%0h", j, oWriteAddress, oDataOut, 10 + j, 32'h200 + 32'(j)); else n_pass++;
      end
      n_checks++; if (oFifoCount !== 3'd0) $display("FAIL drain_count got=%0h exp=0", oFifoCount); else n_pass++;
   endtask

   task automatic test_x0();
      iPipeWriteEn = 1'b1; iPipeWriteAddress = 5'd3; iPipeData = 32'h33;
      iAuxValid = 1'b1; iAuxWriteAddress = 5'd9; iAuxData = 32'h55;
      tick();
      iPipeWriteAddress = 5'd4; iAuxWriteAddress = 5'd0; iAuxData = 32'h77;
      tick();
      n_checks++; if (oFifoCount !== 3'd1) $display("FAIL x0_aux_count got=%0h exp=1", oFifoCount); else n_pass++;
      iPipeWriteAddress = 5'd0; iPipeData = 32'h99; iAuxValid = 1'b0;
      tick();
      n_checks++; if (oWriteEn !== 1'b1 || oWriteAddress !== 5'd9 || oDataOut !== 32'h55)
         $display("FAIL x0_drain got=%0h:%0h exp=9:55", oWriteAddress, oDataOut); else n_pass++;
      n_checks++; if (oFifoCount !== 3'd0) $display("FAIL x0_count got=%0h exp=0", oFifoCount); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 3; k++) begin
         iPipeWriteEn = 1'b1; iPipeWriteAddress = 5'd1; iPipeData = 32'd0;
         iAuxValid = 1'b1; iAuxWriteAddress = 5'(20 + k); iAuxData = 32'h300 + 32'(k);
         tick();
      end
      iPipeWriteEn = 1'b0;
      for (int k = 0; k < 2 * DEPTH; k++) begin
         iAuxWriteAddress = 5'(23 + k); iAuxData = 32'h303 + 32'(k);
         tick();
         n_checks++; if (oFifoCount !== 3'd3) $display("FAIL wrap_count k=%0d got=%0h exp=3", k, oFifoCount); else n_pass++;
         n_checks++; if (oWriteEn !== 1'b1 || oWriteAddress !== 5'(20 + k) || oDataOut !== 32'h300 + 32'(k))
            $display("FAIL wrap_order k=%0d got=%0h:%0h exp=%0h", k, oWriteAddress, oDataOut, 20 + k); else n_pass++;
      end
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if (oWriteAddress !== 5'(28 + k) || oDataOut !== 32'h308 + 32'(k))
            $display("FAIL wrap_tail k=%0d got=%0h:%0h exp=%0h", k, oWriteAddress, oDataOut, 28 + k); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         iPipeWriteEn = 1'b1; iPipeWriteAddress = 5'd2; iPipeData = 32'hBEEF;
         iAuxValid = 1'b1; iAuxWriteAddress = 5'(15 + k); iAuxData = 32'h400 + 32'(k);
         tick();
      end
      idle_inputs();
      #2 iRst = 1'b1;
      model_reset();
      #1;
      n_checks++; if (oWriteEn !== 1'b0 || oWriteAddress !== 5'd0 || oDataOut !== 32'd0)
         $display("FAIL midrst_port got=%0h:%0h:%0h exp=0:0:0", oWriteEn, oWriteAddress, oDataOut); else n_pass++;
      n_checks++; if (oFifoCount !== 3'd0) $display("FAIL midrst_count got=%0h exp=0", oFifoCount); else n_pass++;
      n_checks++; if (oAuxReady !== 1'b0) $display("FAIL midrst_ready got=%0h exp=0", oAuxReady); else n_pass++;
      @(negedge iClk); iRst = 1'b0; #1;
      n_checks++; if (oAuxReady !== 1'b1) $display("FAIL midrel_ready got=%0h exp=1", oAuxReady); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++; if (oWriteEn !== 1'b0) $display("FAIL stale_write k=%0d got=%0h exp=0", k, oWriteEn); else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         iPipeWriteEn = 1'($urandom_range(0, 1)); iPipeWriteAddress = 5'($urandom_range(0, 7)); iPipeData = $urandom;
         iAuxValid = ($urandom_range(0, 2) != 0); iAuxWriteAddress = 5'($urandom_range(0, 7)); iAuxData = $urandom;
         iLookupAddress1 = 5'($urandom_range(0, 7)); iLookupAddress2 = 5'($urandom_range(0, 7));
         #1;
         n_checks++; if (oAuxReady !== (m_q.size() < DEPTH)) $display("FAIL rnd_ready n=%0d got=%0h exp=%0h", n, oAuxReady, (m_q.size() < DEPTH)); else n_pass++;
         n_checks++; if (oStallRequest !== (m_q.size() == DEPTH)) $display("FAIL rnd_stall n=%0d got=%0h exp=%0h", n, oStallRequest, (m_q.size() == DEPTH)); else n_pass++;
         n_checks++; if (oFifoCount !== 3'(m_q.size())) $display("FAIL rnd_count n=%0d got=%0h exp=%0h", n, oFifoCount, m_q.size()); else n_pass++;
         n_checks++; if (oPending1 !== model_pending(iLookupAddress1)) $display("FAIL rnd_pend1 n=%0d got=%0h exp=%0h", n, oPending1, model_pending(iLookupAddress1)); else n_pass++;
         n_checks++; if (oPending2 !== model_pending(iLookupAddress2)) $display("FAIL rnd_pend2 n=%0d got=%0h exp=%0h", n, oPending2, model_pending(iLookupAddress2)); else n_pass++;
         tick();
         n_checks++; if (oWriteEn !== m_we || oWriteAddress !== m_wa || oDataOut !== m_wd)
            $display("FAIL rnd_port n=%0d got=%0h:%0h:%0h exp=%0h:%0h:%0h", n, oWriteEn, oWriteAddress, oDataOut, m_we, m_wa, m_wd); else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_pipe_write();
      test_aux_single();
      test_fill_stall();
      test_x0();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
